snd_latch_irq: RTL and testbench

- Sound-CPU side of the main↔sound command interface: the Z80 end of the main CPU's latch write at IO 0x00 and the source of the reply read at IO 0x08.
- Holds the main→sound command byte and the sound→main reply byte.
- Merges the command-pending flag with the YM2151 IRQ into a single Z80 INT line and an RST vector (M72/M90 scheme).
- Sits inside the sound subsystem, between the main CPU IO decode and the Z80 core.

---
 rtl/snd_pkg.sv | 21 ++
 rtl/snd_latch_irq_if.sv | 30 +++
 rtl/snd_latch_irq_edge_det.sv | 20 ++
 rtl/snd_latch_irq.sv | 100 ++++++++++
 tb/tb_snd_latch_irq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/snd_pkg.sv
// Shared constants for the main<->sound command latch: RST vectors and main-side IO offsets.
package snd_pkg;

  localparam logic [7:0] VEC_IDLE = 8'hFF;
  localparam logic [7:0] VEC_YM   = 8'hEF;
  localparam logic [7:0] VEC_CMD  = 8'hDF;
  localparam logic [7:0] VEC_BOTH = 8'hCF;

  localparam logic [7:0] SND_LATCH_PORT = 8'h00;
  localparam logic [7:0] SND_REPLY_PORT = 8'h08;

  // Clear one vector bit per active source (M72/M90 RST scheme).
  function automatic logic [7:0] build_vec(input logic [7:0] base,
                                           input logic [7:0] ym_mask,
                                           input logic [7:0] cmd_mask,
                                           input logic       ym_act,
                                           input logic       cmd_pending);
    build_vec = base & ~({8{ym_act}} & ym_mask) & ~({8{cmd_pending}} & cmd_mask);
  endfunction

endpackage

// File: rtl/snd_latch_irq_if.sv
// Main-CPU and Z80 side signals of the sound command latch.
interface snd_latch_irq_if;
  logic       main_wr;
  logic [7:0] main_din;
  logic       main_rd;
  logic [7:0] main_dout;
  logic       main_rdy;
  logic       z80_cmd_rd;
  logic [7:0] z80_cmd_dout;
  logic       z80_cmd_ack;
  logic       z80_reply_wr;
  logic [7:0] z80_reply_din;
  logic       ym_irq_n;
  logic       z80_int_ack;
  logic       int_n;
  logic [7:0] int_vector;
  logic       overrun;

  modport slave (
    input  main_wr, main_din, main_rd, z80_cmd_rd, z80_cmd_ack, z80_reply_wr, z80_reply_din,
           ym_irq_n, z80_int_ack,
    output main_dout, main_rdy, z80_cmd_dout, int_n, int_vector, overrun
  );

  modport master (
    output main_wr, main_din, main_rd, z80_cmd_rd, z80_cmd_ack, z80_reply_wr, z80_reply_din,
           ym_irq_n, z80_int_ack,
    input  main_dout, main_rdy, z80_cmd_dout, int_n, int_vector, overrun
  );
endinterface

// File: rtl/snd_latch_irq_edge_det.sv
// 1-bit rising-edge detector; INIT=1 suppresses an edge for a level already high at reset release.
module edge_det #(
  parameter logic INIT = 1'b0
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_hist;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) r_hist <= INIT;
    else          r_hist <= i_sig;
  end

  assign o_rise = i_sig & ~r_hist;

endmodule

// File: rtl/snd_latch_irq.sv
// Sound-CPU end of the main<->sound command latch: command/reply bytes and merged Z80 INT + vector.
module snd_latch_irq
  import snd_pkg::*;
#(
  parameter logic [7:0]  VEC_BASE  = VEC_IDLE,
  parameter int unsigned YM_BIT    = 4,
  parameter int unsigned LATCH_BIT = 5
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  snd_latch_irq_if.slave  snd_bus
);

  localparam logic [7:0] YmMask  = 8'(1) << YM_BIT;
  localparam logic [7:0] CmdMask = 8'(1) << LATCH_BIT;

  logic       w_wr_rise, w_rd_rise, w_ack_rise, w_reply_rise, w_iack_rise;
  logic [7:0] w_live_vec;
  logic       w_unused_cmd_rd;

  logic [7:0] r_cmd_data;
  logic       r_cmd_pending;
  logic [7:0] r_reply_data;
  logic       r_main_rdy;
  logic       r_overrun;
  logic       r_ym_s1, r_ym_act;
  logic       r_int_n;
  logic [7:0] r_int_vector;

  // Reading the command port is side-effect free.
  assign w_unused_cmd_rd = snd_bus.z80_cmd_rd;

  edge_det #(.INIT(1'b1)) u_ed_wr (
    .clk_sys(clk_sys), .reset_n(reset_n), .i_sig(snd_bus.main_wr), .o_rise(w_wr_rise)
  );
  edge_det #(.INIT(1'b1)) u_ed_rd (
    .clk_sys(clk_sys), .reset_n(reset_n), .i_sig(snd_bus.main_rd), .o_rise(w_rd_rise)
  );
  edge_det #(.INIT(1'b1)) u_ed_ack (
    .clk_sys(clk_sys), .reset_n(reset_n), .i_sig(snd_bus.z80_cmd_ack), .o_rise(w_ack_rise)
  );
  edge_det #(.INIT(1'b1)) u_ed_reply (
    .clk_sys(clk_sys), .reset_n(reset_n), .i_sig(snd_bus.z80_reply_wr), .o_rise(w_reply_rise)
  );
  edge_det #(.INIT(1'b1)) u_ed_iack (
    .clk_sys(clk_sys), .reset_n(reset_n), .i_sig(snd_bus.z80_int_ack), .o_rise(w_iack_rise)
  );

  assign w_live_vec = build_vec(VEC_BASE, YmMask, CmdMask, r_ym_act, r_cmd_pending);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_cmd_data    <= 8'h00;
      r_cmd_pending <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (w_wr_rise) begin
      // A same-cycle ack consumes the old command, so that is not an overrun.
      r_cmd_data    <= snd_bus.main_din;
      r_cmd_pending <= 1'b1;
      if (r_cmd_pending && !w_ack_rise) r_overrun <= 1'b1;
    end else if (w_ack_rise) begin
      r_cmd_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_reply_data <= 8'h00;
      r_main_rdy   <= 1'b0;
    end else if (w_reply_rise) begin
      r_reply_data <= snd_bus.z80_reply_din;
      r_main_rdy   <= 1'b1;
    end else if (w_rd_rise) begin
      r_main_rdy   <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_ym_s1      <= 1'b0;
      r_ym_act     <= 1'b0;
      r_int_n      <= 1'b1;
      r_int_vector <= VEC_BASE;
    end else begin
      r_ym_s1  <= ~snd_bus.ym_irq_n;
      r_ym_act <= r_ym_s1;
      r_int_n  <= ~(r_ym_act | r_cmd_pending);
      // Capture on the acknowledge edge, then hold for the rest of the cycle.
      if (w_iack_rise || !snd_bus.z80_int_ack) r_int_vector <= w_live_vec;
    end
  end

  assign snd_bus.main_dout    = r_reply_data;
  assign snd_bus.main_rdy     = r_main_rdy;
  assign snd_bus.z80_cmd_dout = r_cmd_data;
  assign snd_bus.int_n        = r_int_n;
  assign snd_bus.int_vector   = r_int_vector;
  assign snd_bus.overrun      = r_overrun;

endmodule

// File: tb/tb_snd_latch_irq.sv
// Directed bench for snd_latch_irq: command, reply, interrupt vector and reset paths.
module tb_snd_latch_irq;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_sys = ~clk_sys;

  snd_latch_irq_if snd_bus ();

  snd_latch_irq u_dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .snd_bus(snd_bus)
  );

  // Advance n clocks; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    snd_bus.main_wr       = 1'b0;
    snd_bus.main_din      = 8'h00;
    snd_bus.main_rd       = 1'b0;
    snd_bus.z80_cmd_rd    = 1'b0;
    snd_bus.z80_cmd_ack   = 1'b0;
    snd_bus.z80_reply_wr  = 1'b0;
    snd_bus.z80_reply_din = 8'h00;
    snd_bus.ym_irq_n      = 1'b1;
    snd_bus.z80_int_ack   = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(1);

    chk("rst_cmd_dout", snd_bus.z80_cmd_dout, 8'h00);
    chk("rst_main_dout", snd_bus.main_dout, 8'h00);
    chk("rst_main_rdy", {7'd0, snd_bus.main_rdy}, 8'h00);
    chk("rst_int_n", {7'd0, snd_bus.int_n}, 8'h01);
    chk("rst_vector", snd_bus.int_vector, 8'hFF);
    chk("rst_overrun", {7'd0, snd_bus.overrun}, 8'h00);

    // Long main_wr strobe: one capture, INT one clock after pending.
    snd_bus.main_din = 8'h3C;
    snd_bus.main_wr  = 1'b1;
    step(1);
    chk("wr_cmd_dout", snd_bus.z80_cmd_dout, 8'h3C);
    chk("wr_int_n_latency", {7'd0, snd_bus.int_n}, 8'h01);
    step(1);
    chk("wr_int_n", {7'd0, snd_bus.int_n}, 8'h00);
    chk("wr_vector", snd_bus.int_vector, 8'hDF);
    step(8);
    chk("wr_hold_overrun", {7'd0, snd_bus.overrun}, 8'h00);
    snd_bus.main_wr = 1'b0;
    step(1);
    snd_bus.z80_cmd_ack = 1'b1;
    step(2);
    chk("ack_int_n", {7'd0, snd_bus.int_n}, 8'h01);
    chk("ack_vector", snd_bus.int_vector, 8'hFF);
    snd_bus.z80_cmd_ack = 1'b0;
    step(1);

    // Same-cycle write and ack while pending: write wins, no overrun.
    snd_bus.main_din = 8'h66;
    snd_bus.main_wr  = 1'b1;
    step(1);
    snd_bus.main_wr = 1'b0;
    step(1);
    snd_bus.main_din    = 8'h77;
    snd_bus.main_wr     = 1'b1;
    snd_bus.z80_cmd_ack = 1'b1;
    step(1);
    snd_bus.main_wr     = 1'b0;
    snd_bus.z80_cmd_ack = 1'b0;
    step(1);
    chk("race_cmd_dout", snd_bus.z80_cmd_dout, 8'h77);
    chk("race_overrun", {7'd0, snd_bus.overrun}, 8'h00);
    chk("race_pending_int", {7'd0, snd_bus.int_n}, 8'h00);
    snd_bus.z80_cmd_ack = 1'b1;
    step(1);
    snd_bus.z80_cmd_ack = 1'b0;
    step(1);
    chk("race_clear_int", {7'd0, snd_bus.int_n}, 8'h01);

    // Overrun: two writes, no ack between.
    snd_bus.main_din = 8'h11;
    snd_bus.main_wr  = 1'b1;
    step(1);
    snd_bus.main_wr = 1'b0;
    step(1);
    snd_bus.main_din = 8'h22;
    snd_bus.main_wr  = 1'b1;
    step(1);
    chk("ovr_cmd_dout", snd_bus.z80_cmd_dout, 8'h22);
    chk("ovr_flag", {7'd0, snd_bus.overrun}, 8'h01);
    snd_bus.main_wr     = 1'b0;
    snd_bus.z80_cmd_ack = 1'b1;
    step(2);
    snd_bus.z80_cmd_ack = 1'b0;
    step(1);
    chk("ovr_sticky", {7'd0, snd_bus.overrun}, 8'h01);
    chk("ovr_int_clear", {7'd0, snd_bus.int_n}, 8'h01);

    // YM + command, vector frozen across int_ack.
    snd_bus.main_din = 8'h44;
    snd_bus.main_wr  = 1'b1;
    step(1);
    snd_bus.main_wr  = 1'b0;
    snd_bus.ym_irq_n = 1'b0;
    step(4);
    chk("both_vector", snd_bus.int_vector, 8'hCF);
    snd_bus.z80_int_ack = 1'b1;
    step(1);
    chk("iack_vector", snd_bus.int_vector, 8'hCF);
    snd_bus.z80_cmd_ack = 1'b1;
    step(3);
    chk("iack_frozen", snd_bus.int_vector, 8'hCF);
    snd_bus.z80_cmd_ack = 1'b0;
    snd_bus.z80_int_ack = 1'b0;
    step(1);
    chk("ym_only_vector", snd_bus.int_vector, 8'hEF);
    chk("ym_only_int_n", {7'd0, snd_bus.int_n}, 8'h00);
    snd_bus.ym_irq_n = 1'b1;
    step(4);
    chk("ym_clear_vector", snd_bus.int_vector, 8'hFF);
    chk("ym_clear_int_n", {7'd0, snd_bus.int_n}, 8'h01);

    // Reply path.
    snd_bus.z80_reply_din = 8'hA5;
    snd_bus.z80_reply_wr  = 1'b1;
    step(1);
    chk("reply_rdy", {7'd0, snd_bus.main_rdy}, 8'h01);
    chk("reply_dout", snd_bus.main_dout, 8'hA5);
    snd_bus.z80_reply_wr = 1'b0;
    step(1);
    snd_bus.main_rd = 1'b1;
    step(1);
    chk("read_rdy", {7'd0, snd_bus.main_rdy}, 8'h00);
    snd_bus.main_rd = 1'b0;
    step(1);
    snd_bus.z80_reply_din = 8'h5A;
    snd_bus.z80_reply_wr  = 1'b1;
    snd_bus.main_rd       = 1'b1;
    step(1);
    chk("rrace_rdy", {7'd0, snd_bus.main_rdy}, 8'h01);
    chk("rrace_dout", snd_bus.main_dout, 8'h5A);
    snd_bus.z80_reply_wr = 1'b0;
    snd_bus.main_rd      = 1'b0;
    step(1);

    // Reset mid-operation with main_wr held high across release.
    snd_bus.main_din = 8'h99;
    snd_bus.main_wr  = 1'b1;
    step(1);
    snd_bus.main_din = 8'hBB;
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
    chk("mrst_cmd_dout", snd_bus.z80_cmd_dout, 8'h00);
    chk("mrst_rdy", {7'd0, snd_bus.main_rdy}, 8'h00);
    chk("mrst_dout", snd_bus.main_dout, 8'h00);
    chk("mrst_int_n", {7'd0, snd_bus.int_n}, 8'h01);
    chk("mrst_vector", snd_bus.int_vector, 8'hFF);
    chk("mrst_overrun", {7'd0, snd_bus.overrun}, 8'h00);
    snd_bus.main_wr = 1'b0;
    step(1);
    snd_bus.main_wr = 1'b1;
    step(1);
    chk("mrst_rewrite", snd_bus.z80_cmd_dout, 8'hBB);
    step(1);
    chk("mrst_rewrite_int", {7'd0, snd_bus.int_n}, 8'h00);
    snd_bus.main_wr = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
